// File: rtl/btn_event_gen.sv
// Pushbutton and switch event generator: press/release/auto-repeat pulses per button,
// switch change pulses, and a shared timebase tick.
module btn_event_gen #(
  parameter int unsigned CLK_FREQUENCY_HZ   = 100000000,
  parameter int unsigned TICK_HZ            = 1000,
  parameter int unsigned REPEAT_DELAY_TICKS = 500,
  parameter int unsigned REPEAT_RATE_TICKS  = 100,
  parameter int unsigned SIMULATE           = 0,
  parameter int unsigned SIMULATE_TICK_CNT  = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  pbtn_db,
  input  logic [15:0] swtch_db,
  output logic [4:0]  btn_press,
  output logic [4:0]  btn_release,
  output logic [4:0]  btn_repeat,
  output logic [4:0]  btn_held,
  output logic        sw_change,
  output logic [15:0] sw_delta,
  output logic        tick
);

  localparam int unsigned NBTN    = 5;
  localparam int unsigned SW_W    = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TOP     = (SIMULATE != 0) ? SIMULATE_TICK_CNT
                                                    : (CLK_FREQUENCY_HZ / TICK_HZ - 1);
  localparam int unsigned PRESC_W = (TOP < 1) ? 1 : $clog2(TOP + 1);

  localparam logic [PRESC_W-1:0] PRESC_TOP  = PRESC_W'(TOP);
  localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0]   RATE_LAST  = CNT_W'(REPEAT_RATE_TICKS - 1);
  localparam bit                 REPEAT_EN  = (REPEAT_DELAY_TICKS != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  logic [NBTN-1:0]    prev_btn_q, prev_btn_d;
  logic [SW_W-1:0]    prev_sw_q, prev_sw_d;

  btn_state_e         state_q [NBTN];
  btn_state_e         state_d [NBTN];
  logic [CNT_W-1:0]   cnt_q   [NBTN];
  logic [CNT_W-1:0]   cnt_d   [NBTN];

  logic [NBTN-1:0]    btn_press_q, btn_press_d;
  logic [NBTN-1:0]    btn_release_q, btn_release_d;
  logic [NBTN-1:0]    btn_repeat_q, btn_repeat_d;
  logic [NBTN-1:0]    btn_held_q, btn_held_d;
  logic               sw_change_q, sw_change_d;
  logic [SW_W-1:0]    sw_delta_q, sw_delta_d;

  logic [NBTN-1:0]    btn_cur;
  logic [NBTN-1:0]    btn_rise;
  logic [NBTN-1:0]    btn_fall;
  logic [SW_W-1:0]    sw_xor;

  assign btn_cur  = pbtn_db[5:1];
  assign btn_rise = btn_cur & ~prev_btn_q;
  assign btn_fall = ~btn_cur & prev_btn_q;
  assign sw_xor   = swtch_db ^ prev_sw_q;

  // Prescaler; tick_q is registered so it is high exactly while presc_q == TOP.
  always_comb begin
    presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + PRESC_W'(1);
    tick_d  = (presc_d == PRESC_TOP);
  end

  // Input history and switch change detection.
  always_comb begin
    prev_btn_d  = btn_cur;
    prev_sw_d   = swtch_db;
    sw_delta_d  = sw_xor;
    sw_change_d = |sw_xor;
  end

  // Per-button IDLE/DELAY/REPEAT machines; a falling edge overrides any tick.
  always_comb begin
    btn_press_d   = '0;
    btn_release_d = '0;
    btn_repeat_d  = '0;
    btn_held_d    = '0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (btn_fall[i]) begin
        btn_release_d[i] = 1'b1;
        state_d[i]       = ST_IDLE;
        cnt_d[i]         = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (btn_rise[i]) begin
              btn_press_d[i] = 1'b1;
              cnt_d[i]       = '0;
              if (REPEAT_EN) begin
                state_d[i] = ST_DELAY;
              end
            end
          end
          ST_DELAY: begin
            if (tick_q) begin
              if (cnt_q[i] == DELAY_LAST) begin
                btn_repeat_d[i] = 1'b1;
                cnt_d[i]        = '0;
                state_d[i]      = ST_REPEAT;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (tick_q) begin
              if (cnt_q[i] == RATE_LAST) begin
                btn_repeat_d[i] = 1'b1;
                cnt_d[i]        = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      // With auto-repeat disabled the machine stays in IDLE, so held tracks the input.
      btn_held_d[i] = (state_d[i] != ST_IDLE) || (!REPEAT_EN && btn_cur[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q       <= '0;
      tick_q        <= 1'b0;
      prev_btn_q    <= '0;
      prev_sw_q     <= '0;
      btn_press_q   <= '0;
      btn_release_q <= '0;
      btn_repeat_q  <= '0;
      btn_held_q    <= '0;
      sw_change_q   <= 1'b0;
      sw_delta_q    <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      prev_btn_q    <= prev_btn_d;
      prev_sw_q     <= prev_sw_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      btn_repeat_q  <= btn_repeat_d;
      btn_held_q    <= btn_held_d;
      sw_change_q   <= sw_change_d;
      sw_delta_q    <= sw_delta_d;
      for (int unsigned i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;
  assign btn_repeat  = btn_repeat_q;
  assign btn_held    = btn_held_q;
  assign sw_change   = sw_change_q;
  assign sw_delta    = sw_delta_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen: a tick-counting reference model predicts every
// output cycle, and a negedge monitor compares the DUT against the queued predictions.
module tb_btn_event_gen;

  localparam int TOP = 5;
  localparam int RD  = 3;
  localparam int RR  = 2;
  localparam int PER = TOP + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  pbtn_db;
  logic [15:0] swtch_db;
  logic [4:0]  btn_press, btn_release, btn_repeat, btn_held;
  logic        sw_change;
  logic [15:0] sw_delta;
  logic        tick;

  always #5 clk = ~clk;

  btn_event_gen #(
    .CLK_FREQUENCY_HZ  (100000000),
    .TICK_HZ           (1000),
    .REPEAT_DELAY_TICKS(RD),
    .REPEAT_RATE_TICKS (RR),
    .SIMULATE          (1),
    .SIMULATE_TICK_CNT (TOP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pbtn_db    (pbtn_db),
    .swtch_db   (swtch_db),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .btn_held   (btn_held),
    .sw_change  (sw_change),
    .sw_delta   (sw_delta),
    .tick       (tick)
  );

  typedef struct packed {
    logic [4:0]  press;
    logic [4:0]  rel;
    logic [4:0]  rep;
    logic [4:0]  held;
    logic        chg;
    logic [15:0] delta;
    logic        tick;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: cycles since reset, and ticks elapsed since each press.
  logic [4:0]  m_prev;
  logic [15:0] m_prev_sw;
  int          m_k;
  bit          m_active [5];
  int          m_n      [5];

  always @(posedge clk) begin : model
    obs_t e;
    bit   tick_now;
    bit   b;
    e = '0;
    if (!reset_n) begin
      m_prev    = '0;
      m_prev_sw = '0;
      m_k       = 0;
      for (int i = 0; i < 5; i++) begin
        m_active[i] = 1'b0;
        m_n[i]      = 0;
      end
    end else begin
      tick_now = ((m_k % PER) == TOP);
      for (int i = 0; i < 5; i++) begin
        b = pbtn_db[i+1];
        if (!b && m_prev[i]) begin
          e.rel[i]    = 1'b1;
          m_active[i] = 1'b0;
        end else if (b && !m_prev[i]) begin
          e.press[i]  = 1'b1;
          m_active[i] = 1'b1;
          m_n[i]      = 0;
        end else if (m_active[i] && tick_now) begin
          m_n[i] = m_n[i] + 1;
          if (m_n[i] >= RD && ((m_n[i] - RD) % RR) == 0) e.rep[i] = 1'b1;
        end
        e.held[i] = m_active[i];
      end
      e.delta   = swtch_db ^ m_prev_sw;
      e.chg     = |e.delta;
      m_prev    = pbtn_db[5:1];
      m_prev_sw = swtch_db;
      m_k       = m_k + 1;
      e.tick    = ((m_k % PER) == TOP);
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("btn_press",   16'(btn_press),   16'(e.press));
      chk("btn_release", 16'(btn_release), 16'(e.rel));
      chk("btn_repeat",  16'(btn_repeat),  16'(e.rep));
      chk("btn_held",    16'(btn_held),    16'(e.held));
      chk("sw_change",   16'(sw_change),   16'(e.chg));
      chk("sw_delta",    sw_delta,         e.delta);
      chk("tick",        16'(tick),        16'(e.tick));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit found;
    reset_n  = 1'b0;
    pbtn_db  = '0;
    swtch_db = '0;
    step(4);
    reset_n = 1'b1;
    step(20);

    // Long hold, then a second press whose release lands on a repeat-due tick.
    pbtn_db[2] = 1'b1;
    step(60);
    pbtn_db[2] = 1'b0;
    step(5);
    pbtn_db[2] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (m_n[1] == 4 && (m_k % PER) == TOP) begin
        pbtn_db[2] = 1'b0;
        found      = 1'b1;
      end else begin
        step(1);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL release_race_setup: got no aligned tick, expected one within 200 cycles");
      pbtn_db[2] = 1'b0;
    end
    step(4);

    // Ignored reset button, then a short press.
    for (int t = 0; t < 4; t++) begin
      pbtn_db[0] = ~pbtn_db[0];
      step(2);
    end
    pbtn_db[5] = 1'b1;
    step(2);
    pbtn_db[5] = 1'b0;
    step(5);

    swtch_db = 16'h8001;
    step(5);

    // Reset in REPEAT with the button still held across release.
    pbtn_db[2] = 1'b1;
    step(40);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(6);
    pbtn_db[2] = 1'b0;
    step(4);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) pbtn_db[$urandom_range(0, 5)] = ~pbtn_db[$urandom_range(0, 5)];
      if ($urandom_range(0, 49) == 0) swtch_db = swtch_db ^ 16'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        step(int'($urandom_range(1, 3)));
        reset_n = 1'b1;
      end
      step(1);
    end

    step(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event_gen.md
BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 Parameter CLK_FREQUENCY_HZ, default 100000000, input clock frequency.
REQ-002 Parameter TICK_HZ, default 1000, timebase tick rate (1 ms).
REQ-003 Parameter REPEAT_DELAY_TICKS, default 500, ticks from press to first repeat; 0 disables auto-repeat.
REQ-004 Parameter REPEAT_RATE_TICKS, default 100, ticks between subsequent repeats; must be >= 1.
REQ-005 Parameter SIMULATE, default 0, selects the short tick period when 1.
REQ-006 Parameter SIMULATE_TICK_CNT, default 5, prescaler terminal count when SIMULATE=1.
REQ-007 clk  input  1  single system clock; all logic is on its rising edge.
REQ-008 reset_n  input  1  reset, synchronous, active-low.
REQ-009 pbtn_db  input  6  debounced pushbuttons; bit 0 is the CPU reset button and is ignored; bits 5:1 are processed.
REQ-010 swtch_db  input  16  debounced slider switches.
REQ-011 btn_press  output  5  one-cycle pulse per button on its rising edge; bit i maps to pbtn_db[i+1].
REQ-012 btn_release  output  5  one-cycle pulse per button on its falling edge.
REQ-013 btn_repeat  output  5  one-cycle auto-repeat pulse per button.
REQ-014 btn_held  output  5  registered level, high while the button is in DELAY or REPEAT.
REQ-015 sw_change  output  1  one-cycle pulse when any switch bit changes.
REQ-016 sw_delta  output  16  bits that changed, valid only while sw_change=1; zero otherwise.
REQ-017 tick  output  1  one-cycle timebase pulse, exported for other blocks.

Function
REQ-018 The prescaler SHALL count 0..TOP and wrap to 0; TOP = SIMULATE ? SIMULATE_TICK_CNT : CLK_FREQUENCY_HZ/TICK_HZ - 1.
REQ-019 tick SHALL be high for exactly the one cycle in which the prescaler equals TOP; the tick period is TOP+1 clocks.
REQ-020 Inputs SHALL be registered once (prev_btn, prev_sw); edges are current XOR prev.
REQ-021 Each output pulse SHALL appear on the cycle after the clock edge at which the input change is first sampled (1-cycle latency).
REQ-022 Each button SHALL have an independent FSM with states IDLE, DELAY, REPEAT and a 16-bit tick counter.
REQ-023 IDLE, rising edge: pulse btn_press, clear the counter, go to DELAY, or stay IDLE-held if REPEAT_DELAY_TICKS=0.
REQ-024 DELAY, on each tick: increment the counter; at count REPEAT_DELAY_TICKS-1, pulse btn_repeat, clear the counter, go to REPEAT.
REQ-025 REPEAT, on each tick: increment the counter; at count REPEAT_RATE_TICKS-1, pulse btn_repeat and clear the counter.
REQ-026 In any state, a falling edge SHALL pulse btn_release, clear the counter and go to IDLE.
REQ-027 A falling edge SHALL take priority over a tick in the same cycle, so no repeat pulse is produced.
REQ-028 btn_press and btn_repeat SHALL never assert in the same cycle for the same button.
REQ-029 When REPEAT_DELAY_TICKS=0, btn_held SHALL still follow the button and btn_repeat SHALL stay 0.
REQ-030 Simultaneous events on different buttons SHALL be reported independently in the same cycle.
REQ-031 sw_change SHALL equal |(swtch_db ^ prev_sw), registered; sw_delta SHALL equal the XOR, registered.
REQ-032 Counters SHALL clear on every state change, so wrap-around of the 16-bit counter is unreachable.

Reset
REQ-033 While reset_n=0 at a clock edge, all outputs, the prescaler, counters, prev_btn and prev_sw SHALL clear to 0 and all FSMs SHALL enter IDLE.
REQ-034 A button or switch already high when reset is released SHALL produce btn_press or sw_change on the second cycle after release.
REQ-035 Reset asserted mid-DELAY or mid-REPEAT SHALL abort the sequence with no release pulse.

Verification (SIMULATE=1, SIMULATE_TICK_CNT=5, REPEAT_DELAY_TICKS=3, REPEAT_RATE_TICKS=2)
REQ-036 Check the timebase: free run -> tick exactly every 6 clocks, one cycle wide.
REQ-037 Check press and hold: pbtn_db[2] held high -> btn_press[1] once, then first btn_repeat[1] after the 3rd tick, then repeats spaced exactly 12 clocks apart, with btn_held[1]=1 throughout.
REQ-038 Check release racing a tick: release pbtn_db[2] on the same cycle as a repeat-due tick -> btn_release[1] asserted, btn_repeat[1] not asserted, btn_held[1]=0 next cycle.
REQ-039 Check the ignored bit and a short press: toggle pbtn_db[0] -> no outputs; a 2-clock press of pbtn_db[5] -> btn_press[4] then btn_release[4], with no repeat.
REQ-040 Check switches: swtch_db 0x0000 -> 0x8001 -> sw_change one cycle with sw_delta=0x8001, then sw_change=0 and sw_delta=0x0000.
REQ-041 Check reset mid-repeat: drive reset_n low while in REPEAT -> all outputs 0; with the button still high at release -> btn_press on the 2nd cycle after release.
